i2c_angle_target: RTL

- Synthesizable I2C target that answers the I2C read transactions issued by the motor-angle controller on its sck/sda pins.
- It models the magnetic encoder's register map and serves a live 12-bit angle supplied by an internal source (a test stimulus or an emulated encoder).
- It is used in system benches and FPGA loopback builds so the angle controller can be exercised without the physical encoder.
- It oversamples sck/sda on the system clock; it generates no bus clock.

---
 rtl/i2c_angle_target.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/i2c_angle_target.sv
// I2C target emulating a magnetic encoder's register map: serves a live 12-bit angle
// as two read bytes, accepts pointer writes, and oversamples sck/sda on the system clock.
module i2c_angle_target #(
    parameter logic [6:0] DEV_ADDR     = 7'h36,
    parameter logic [7:0] ANGLE_HI_REG = 8'h0C
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sck,
    inout  wire         sda,
    input  logic [11:0] raw_angle,
    output logic        busy,
    output logic [7:0]  reg_ptr,
    output logic        rd_strobe,
    output logic [3:0]  fsm_state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        REG      = 4'd3,
        REG_ACK  = 4'd4,
        WDATA    = 4'd5,
        DATA_ACK = 4'd6,
        TX       = 4'd7,
        TX_ACK   = 4'd8,
        IGNORE   = 4'd9
    } state_t;

    state_t      state;
    logic        sck_s1, sck_s2, sck_d;
    logic        sda_s1, sda_s2, sda_d;
    logic        sck_rise, sck_fall, start_det, stop_det;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_sr;
    logic [7:0]  shift_in;
    logic [7:0]  first_byte;
    logic [11:0] snapshot;
    logic        ack_phase;
    logic        rw;
    logic        drive_low;

    function automatic logic [7:0] read_byte(input logic [7:0] ptr, input logic [11:0] ang);
        if (ptr == ANGLE_HI_REG)
            return {4'h0, ang[11:8]};
        else if (ptr == ANGLE_HI_REG + 8'd1)
            return ang[7:0];
        else
            return 8'h00;
    endfunction

    // Synchronizers reset to the idle bus level so release of reset creates no false START.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_s1 <= 1'b1; sck_s2 <= 1'b1; sck_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            sck_s1 <= sck;    sck_s2 <= sck_s1; sck_d <= sck_s2;
            sda_s1 <= sda;    sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign sck_rise   = sck_s2 & ~sck_d;
    assign sck_fall   = ~sck_s2 & sck_d;
    assign start_det  = sck_s2 & sda_d & ~sda_s2;
    assign stop_det   = sck_s2 & ~sda_d & sda_s2;
    assign shift_in   = {shift_sr[6:0], sda_s2};
    // The first read byte uses raw_angle directly: the snapshot is loaded in the same cycle.
    assign first_byte = read_byte(reg_ptr, raw_angle);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_sr  <= 8'h00;
            snapshot  <= 12'h000;
            ack_phase <= 1'b0;
            rw        <= 1'b0;
            drive_low <= 1'b0;
            busy      <= 1'b0;
            reg_ptr   <= 8'h00;
            rd_strobe <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                drive_low <= 1'b0;
                busy      <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= 4'd0;
                drive_low <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (sck_rise) begin
                            shift_sr <= shift_in;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= 4'd0;
                                ack_phase <= 1'b0;
                                if (state == REG) begin
                                    reg_ptr <= shift_in;
                                    state   <= REG_ACK;
                                end else if (state == WDATA) begin
                                    state <= DATA_ACK;
                                end else if (shift_in[7:1] == DEV_ADDR) begin
                                    rw    <= shift_in[0];
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK, DATA_ACK: begin
                        // First fall asserts ACK, second fall ends it.
                        if (sck_fall) begin
                            if (!ack_phase) begin
                                drive_low <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                drive_low <= 1'b0;
                                bit_cnt   <= 4'd0;
                                if (state == ADDR_ACK && rw) begin
                                    snapshot  <= raw_angle;
                                    drive_low <= ~first_byte[7];
                                    shift_sr  <= {first_byte[6:0], 1'b0};
                                    bit_cnt   <= 4'd1;
                                    state     <= TX;
                                end else if (state == ADDR_ACK) begin
                                    state <= REG;
                                end else begin
                                    if (state == DATA_ACK)
                                        reg_ptr <= reg_ptr + 8'd1;
                                    state <= WDATA;
                                end
                            end
                        end
                    end
                    TX: begin
                        if (sck_fall) begin
                            if (bit_cnt == 4'd8) begin
                                drive_low <= 1'b0;
                                state     <= TX_ACK;
                            end else begin
                                drive_low <= ~shift_sr[7];
                                shift_sr  <= {shift_sr[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (sck_rise) begin
                            rd_strobe <= 1'b1;
                            reg_ptr   <= reg_ptr + 8'd1;
                            if (!sda_s2) begin
                                shift_sr <= read_byte(reg_ptr + 8'd1, snapshot);
                                bit_cnt  <= 4'd0;
                                state    <= TX;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda       = drive_low ? 1'b0 : 1'bz;
    assign fsm_state = state;

endmodule
